// File: rtl/compactor_arbiter.sv
// Round-robin, packet-locked arbiter sharing one Compactor among several streams,
// with a tag FIFO that routes in-order results back. Optional COMPACTOR_ARB_STATS_EN adds per-requester packet counters.
module compactor_arbiter #(
  parameter int NUM_REQUESTERS  = 4,
  parameter int NUM_ELEMENTS    = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 16,
  localparam int ID_W   = $clog2(NUM_REQUESTERS),
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING),
  localparam int CNT_W  = PTR_W + 1,
  localparam int BEAT_W = NUM_ELEMENTS * DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQUESTERS*BEAT_W-1:0]       req_data,
  input  logic [NUM_REQUESTERS*NUM_ELEMENTS-1:0] req_keep,
  input  logic [NUM_REQUESTERS-1:0]              req_last,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  output logic [BEAT_W-1:0]                      cmp_in_data,
  output logic [NUM_ELEMENTS-1:0]                cmp_in_keep,
  output logic                                   cmp_in_last,
  output logic                                   cmp_in_valid,
  input  logic                                   cmp_in_ready,
  input  logic                                   cmp_out_last,
  input  logic                                   cmp_out_valid,
  output logic                                   cmp_out_ready,
  output logic [NUM_REQUESTERS-1:0]              res_valid,
  input  logic [NUM_REQUESTERS-1:0]              res_ready,
  output logic [ID_W-1:0]                        res_id,
  output logic [CNT_W-1:0]                       outstanding,
`ifdef COMPACTOR_ARB_STATS_EN
  output logic [NUM_REQUESTERS*32-1:0]           stat_packets,
`endif
  output logic                                   tag_error
);

  // Handshake: a beat moves on any cycle where valid & ready are both high;
  // valid never depends combinationally on the ready of the same interface.

  localparam int SUM_W = ID_W + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state;
  logic [ID_W-1:0]        gnt;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_found;

  logic [ID_W-1:0]        tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [ID_W-1:0]        head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  logic [NUM_REQUESTERS-1:0][BEAT_W-1:0]       data_v;
  logic [NUM_REQUESTERS-1:0][NUM_ELEMENTS-1:0] keep_v;

  // Result framing is owned by the Compactor; only the beat count matters here.
  logic unused;
  assign unused = cmp_out_last;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    logic [SUM_W-1:0] s;
    s = {1'b0, base} + SUM_W'(k);
    if (s >= SUM_W'(NUM_REQUESTERS)) s = s - SUM_W'(NUM_REQUESTERS);
    return s[ID_W-1:0];
  endfunction

  assign data_v = req_data;
  assign keep_v = req_keep;

  assign fifo_full  = (outstanding == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (outstanding == '0);
  assign head       = tag_mem[rd_ptr];
  assign res_id     = head;

  assign cmp_in_data  = data_v[gnt];
  assign cmp_in_keep  = keep_v[gnt];
  assign cmp_in_last  = req_last[gnt];
  assign cmp_in_valid = (state == LOCKED) & req_valid[gnt] & ~fifo_full;

  assign push          = cmp_in_valid & cmp_in_ready;
  assign cmp_out_ready = res_ready[head] & ~fifo_empty;
  assign pop           = cmp_out_valid & cmp_out_ready;

  always_comb begin
    req_ready = '0;
    if (state == LOCKED) req_ready[gnt] = cmp_in_ready & ~fifo_full;
  end

  always_comb begin
    res_valid = '0;
    if (cmp_out_valid & ~fifo_empty) res_valid[head] = 1'b1;
  end

  // Scan downward so the requester closest to the pointer is the last writer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr;
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      if (req_valid[rr_index(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_id    = rr_index(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt   <= pick_id;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (push & cmp_in_last) begin
            rr_ptr <= (gnt == ID_W'(NUM_REQUESTERS - 1)) ? '0 : gnt + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      tag_error   <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= gnt;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      // A result with no tag means the Compactor and this block disagree; latch it.
      if (cmp_out_valid & fifo_empty) tag_error <= 1'b1;
    end
  end

`ifdef COMPACTOR_ARB_STATS_EN
  logic [NUM_REQUESTERS-1:0][31:0] pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (push & cmp_in_last) begin
      pkt_cnt[gnt] <= pkt_cnt[gnt] + 32'd1;
    end
  end

  assign stat_packets = pkt_cnt;
`endif

endmodule

// File: tb/tb_compactor_arbiter.sv
// Randomized bench for compactor_arbiter: queue-based arbitration/tag model plus a
// 6-cycle loopback Compactor whose beats carry their origin for routing checks.
module tb_compactor_arbiter;

  localparam int N      = 4;
  localparam int NE     = 8;
  localparam int DW     = 32;
  localparam int MAXO   = 8;
  localparam int LAT    = 6;
  localparam int ID_W   = $clog2(N);
  localparam int CNT_W  = $clog2(MAXO) + 1;
  localparam int BEAT_W = NE * DW;

  localparam int M_FAIR = 0;
  localparam int M_RAND = 1;
  localparam int M_HOLD = 2;
  localparam int M_ERR  = 3;

  typedef logic [BEAT_W-1:0] val_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N*BEAT_W-1:0] req_data;
  logic [N*NE-1:0]     req_keep;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [BEAT_W-1:0]   cmp_in_data;
  logic [NE-1:0]       cmp_in_keep;
  logic                cmp_in_last;
  logic                cmp_in_valid;
  logic                cmp_in_ready;
  logic                cmp_out_last;
  logic                cmp_out_valid;
  logic                cmp_out_ready;
  logic [N-1:0]        res_valid;
  logic [N-1:0]        res_ready;
  logic [ID_W-1:0]     res_id;
  logic [CNT_W-1:0]    outstanding;
  logic                tag_error;
`ifdef COMPACTOR_ARB_STATS_EN
  logic [N*32-1:0]     stat_packets;
`endif

  always #5 clk = ~clk;

  compactor_arbiter #(
    .NUM_REQUESTERS (N),
    .NUM_ELEMENTS   (NE),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_data     (req_data),
    .req_keep     (req_keep),
    .req_last     (req_last),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .cmp_in_data  (cmp_in_data),
    .cmp_in_keep  (cmp_in_keep),
    .cmp_in_last  (cmp_in_last),
    .cmp_in_valid (cmp_in_valid),
    .cmp_in_ready (cmp_in_ready),
    .cmp_out_last (cmp_out_last),
    .cmp_out_valid(cmp_out_valid),
    .cmp_out_ready(cmp_out_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_id       (res_id),
    .outstanding  (outstanding),
`ifdef COMPACTOR_ARB_STATS_EN
    .stat_packets (stat_packets),
`endif
    .tag_error    (tag_error)
  );

  // Loopback Compactor: lane 0 of each beat encodes {origin, sequence}.
  typedef struct {
    logic [31:0] word;
    logic        last;
    int          t;
  } lb_entry_t;
  lb_entry_t lb_q[$];

  // Reference model: expected tag order, grant ownership, sticky error, packet counts.
  logic [ID_W-1:0] exp_q[$];
  bit              m_busy;
  int              m_owner;
  int              m_ptr;
  bit              m_err;
  int              m_pkts[N];

  bit          have_beat[N];
  int          beats_left[N];
  int          send_seq[N];
  int          recv_seq[N];
  logic [BEAT_W-1:0] beat_data[N];
  logic [NE-1:0]     beat_keep[N];
  bit          beat_last[N];

  bit          acc[N];
  bit          in_fire;
  bit          out_fire;
  logic [31:0] cap_word;
  bit          cap_last;

  int cycle;
  int mode;
  int checks;
  int errors;
  int fair_next;
  int last_end;
  bit fair_started;

  task automatic check_eq(input string tag, input val_t got, input val_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (!have_beat[i] && mode != M_ERR &&
          (mode == M_FAIR || $urandom_range(0, 99) < 60)) begin
        if (beats_left[i] == 0) beats_left[i] = (mode == M_FAIR) ? 2 : int'($urandom_range(1, 4));
        for (int l = 1; l < NE; l++) beat_data[i][l*DW +: DW] = $urandom;
        beat_data[i][DW-1:0] = {8'(i), 24'(send_seq[i])};
        beat_keep[i] = NE'($urandom);
        beat_last[i] = (beats_left[i] == 1);
        send_seq[i]++;
        have_beat[i] = 1'b1;
      end
      req_data[i*BEAT_W +: BEAT_W] = beat_data[i];
      req_keep[i*NE +: NE]         = beat_keep[i];
      req_last[i]                  = beat_last[i];
      req_valid[i]                 = have_beat[i];
      res_ready[i] = (mode == M_FAIR) ? 1'b1 :
                     (mode == M_HOLD) ? 1'b0 : ($urandom_range(0, 99) < 70);
    end
    cmp_in_ready  = (mode == M_RAND) ? ($urandom_range(0, 99) < 80) : 1'b1;
    cmp_out_valid = (mode == M_ERR) || (lb_q.size() > 0 && lb_q[0].t <= cycle);
    cmp_out_last  = (lb_q.size() > 0) ? lb_q[0].last : 1'b0;
  endtask

  task automatic check_and_model();
    int            sz;
    bit            full;
    bit            empty;
    int            head;
    int            src;
    bit            found;
    bit            e_cin_valid;
    bit            e_cout_ready;
    bit            push;
    bit            pop;
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_res;
    logic [N-1:0]  oh;
    sz    = exp_q.size();
    full  = (sz == MAXO);
    empty = (sz == 0);
    head  = empty ? 0 : int'(exp_q[0]);
    e_ready = '0;
    e_res   = '0;
    e_cin_valid = m_busy && req_valid[m_owner] && !full;
    if (m_busy && cmp_in_ready && !full) e_ready[m_owner] = 1'b1;
    if (cmp_out_valid && !empty) e_res[head] = 1'b1;
    e_cout_ready = !empty && res_ready[head];

    check_eq("req_ready", val_t'(req_ready), val_t'(e_ready));
    check_eq("cmp_in_valid", val_t'(cmp_in_valid), val_t'(e_cin_valid));
    check_eq("cmp_out_ready", val_t'(cmp_out_ready), val_t'(e_cout_ready));
    check_eq("res_valid", val_t'(res_valid), val_t'(e_res));
    check_eq("outstanding", val_t'(outstanding), val_t'(sz));
    check_eq("tag_error", val_t'(tag_error), val_t'(m_err));
    if (!empty) check_eq("res_id", val_t'(res_id), val_t'(head));
    if (e_cin_valid) begin
      check_eq("cmp_in_data", cmp_in_data, req_data[m_owner*BEAT_W +: BEAT_W]);
      check_eq("cmp_in_keep", val_t'(cmp_in_keep), val_t'(req_keep[m_owner*NE +: NE]));
      check_eq("cmp_in_last", val_t'(cmp_in_last), val_t'(req_last[m_owner]));
    end

    for (int i = 0; i < N; i++) begin
      acc[i] = req_valid[i] && req_ready[i];
      if (acc[i] && mode == M_FAIR) begin
        if (beats_left[i] == 2) begin
          check_eq("fair_order", val_t'(i), val_t'(fair_next));
          if (fair_started) check_eq("fair_gap", val_t'(cycle - last_end), val_t'(2));
          fair_started = 1'b1;
        end
        if (beat_last[i]) begin
          fair_next = (fair_next + 1) % N;
          last_end  = cycle;
        end
      end
    end
    in_fire  = cmp_in_valid && cmp_in_ready;
    cap_word = cmp_in_data[31:0];
    cap_last = cmp_in_last;
    out_fire = cmp_out_valid && cmp_out_ready && lb_q.size() > 0;
    if (out_fire) begin
      src = int'(lb_q[0].word[31:24]);
      oh  = '0;
      if (src < N) oh[src] = 1'b1;
      check_eq("route_valid", val_t'(res_valid), val_t'(oh));
      if (src < N) begin
        check_eq("route_order", val_t'(lb_q[0].word[23:0]), val_t'(recv_seq[src]));
        recv_seq[src] = int'(lb_q[0].word[23:0]) + 1;
      end
    end

    push = e_cin_valid && cmp_in_ready;
    pop  = cmp_out_valid && e_cout_ready;
    if (cmp_out_valid && empty) m_err = 1'b1;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(ID_W'(m_owner));
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % N;
        end
      end
    end else if (push && req_last[m_owner]) begin
      m_pkts[m_owner]++;
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end
  endtask

  task automatic advance();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        have_beat[i] = 1'b0;
        if (beats_left[i] > 0) beats_left[i]--;
      end
    end
    if (out_fire) void'(lb_q.pop_front());
    if (in_fire) lb_q.push_back('{word: cap_word, last: cap_last, t: cycle + LAT});
  endtask

  task automatic run_cycles(input int n, input int m);
    for (int c = 0; c < n; c++) begin
      mode = m;
      drive_inputs();
      @(negedge clk);
      check_and_model();
      @(posedge clk);
      #1;
      cycle++;
      advance();
    end
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", val_t'(req_ready), val_t'(0));
    check_eq("rst_cmp_in_valid", val_t'(cmp_in_valid), val_t'(0));
    check_eq("rst_cmp_out_ready", val_t'(cmp_out_ready), val_t'(0));
    check_eq("rst_res_valid", val_t'(res_valid), val_t'(0));
    check_eq("rst_outstanding", val_t'(outstanding), val_t'(0));
    check_eq("rst_tag_error", val_t'(tag_error), val_t'(0));
    check_eq("rst_res_id", val_t'(res_id), val_t'(0));
    lb_q.delete();
    exp_q.delete();
    m_busy = 1'b0;
    m_owner = 0;
    m_ptr = 0;
    m_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_pkts[i] = 0;
      have_beat[i] = 1'b0;
      beats_left[i] = 0;
      send_seq[i] = 0;
      recv_seq[i] = 0;
      beat_data[i] = '0;
      beat_keep[i] = '0;
      beat_last[i] = 1'b0;
    end
    req_data = '0;
    req_keep = '0;
    req_last = '0;
    req_valid = '0;
    res_ready = '0;
    cmp_in_ready = 1'b0;
    cmp_out_valid = 1'b0;
    cmp_out_last = 1'b0;
    fair_next = 0;
    fair_started = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    rst_n = 1'b1;
    checks = 0;
    errors = 0;
    cycle = 0;
    mode = M_RAND;
    apply_reset();
    run_cycles(40, M_FAIR);
    run_cycles(600, M_RAND);
    run_cycles(20, M_HOLD);
    run_cycles(300, M_RAND);
    apply_reset();
    run_cycles(3, M_ERR);
    run_cycles(400, M_RAND);
`ifdef COMPACTOR_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check_eq("stat_packets", val_t'(stat_packets[i*32 +: 32]), val_t'(m_pkts[i]));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
